boron_key_schedule: RTL and testbench
=====================================

# boron_key_schedule

Sequential Boron-80 key schedule: loads an 80-bit master key and delivers the 26 round keys K0..K25 one at a time over a valid/ready handshake. It sits directly upstream of the add-round-key stage, which XORs the low 64 bits of each delivered key into the state. Only one key register is held; each round key is derived from the previous one by the Boron key update.

## Interface
- No parameters. Round count (25) and key width (80) are fixed by the cipher.
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- start_i  in  1  begin a schedule run; sampled only in IDLE
- key_i  in  80  master key; captured when start_i is accepted
- decrypt_i  in  1  key order select, captured with start_i; only present with BORON_KS_DECRYPT_EN
- ready_i  in  1  consumer accepts current_key_o this cycle
- current_key_o  out  80  round key; stable while valid_o=1 and ready_i=0
- round_o  out  5  index i of the key on current_key_o (0..25)
- valid_o  out  1  current_key_o/round_o are valid
- last_o  out  1  high with valid_o on the final key of the run
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse after the final key is accepted

## Operation
- Forward update for step i (1..25): K = K <<< 13; K[3:0] = S(K[3:0]); K[63:59] ^= i[4:0].
- S = {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6} (index 0..F).
- Inverse step i: K[63:59] ^= i; K[3:0] = Sinv(K[3:0]); K = K >>> 13; Sinv = {A,3,9,E,1,D,F,4,C,5,7,2,6,8,0,B}.
- FSM states: IDLE, PRECOMP (decrypt builds only), EMIT, DONE.
- IDLE: start_i=1 -> capture key_i into key register, round counter = 0, go to EMIT (encrypt) or PRECOMP (decrypt).
- PRECOMP: apply forward step i per cycle for i = 1..25 with valid_o=0; after step 25 the counter is 25, go to EMIT.
- EMIT: valid_o=1. On valid_o && ready_i:
  - not last: encrypt applies forward step counter+1 and increments the counter; decrypt applies inverse step counter and decrements it.
  - last (round 25 encrypt, round 0 decrypt): go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- start_i outside IDLE is ignored. key_i changes after capture have no effect.
- last_o = valid_o && (round_o == final index).

## Timing
- Reset values: current_key_o=0, round_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0, FSM=IDLE.
- Encrypt: K0 is valid in the cycle after start_i is accepted (1-cycle latency).
- Each accepted key produces the next key one cycle later. With ready_i held high, throughput is 1 key/cycle and the 26 keys occupy 26 consecutive cycles.
- Decrypt: K25 is valid 26 cycles after start_i (25 PRECOMP cycles plus 1).
- done_o is asserted the cycle after the final handshake. A new start_i is accepted no earlier than the cycle after done_o.
- ready_i low stalls the block indefinitely. Outputs hold exactly and there is no timeout.
- Asserting rst_ni low at any point, including mid-run or mid-PRECOMP, immediately clears all outputs and state. No partial key is emitted afterwards.
- All outputs are registered. There is no combinational path from ready_i to any output.

## Configuration
- BORON_KS_DECRYPT_EN defined: decrypt_i port, PRECOMP state and inverse update are present. decrypt_i=1 emits K25, K24, ..., K0 with round_o counting down.
- Not defined: decrypt_i port is absent, encrypt order only, and there is no PRECOMP logic.

## Test plan
- Encrypt key_i=0, ready_i=1: K0=80'h0, round 0. Next cycle K1=80'h0000_0800_0000_0000_000E, round 1. last_o is high only at round 25, and done_o pulses the next cycle.
- Backpressure: hold ready_i=0 for 5 cycles at round 3. current_key_o and round_o stay constant. When ready_i=1, round 4 follows one cycle later with the value of an unstalled run.
- Random key: compare all 26 keys against the software model for 100 random key_i values, with random ready_i.
- Decrypt (macro on), key_i=0: first valid key appears 26 cycles after start, at round 25. The sequence equals the encrypt sequence reversed, and the final key at round 0 is 80'h0.
- start_i pulsed mid-run with a different key_i: ignored, and the running sequence is unchanged.
- rst_ni low during round 10: all outputs go to 0 at once. After release, a new start yields K0 of the new key.

Source files
------------

// File: rtl/boron_key_schedule.sv
// boron_key_schedule: Boron-80 round keys K0..K25 over a valid/ready handshake.
// Optional feature macro BORON_KS_DECRYPT_EN: decrypt_i, PRECOMP, reverse order.
module boron_key_schedule (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [79:0] key_i,
`ifdef BORON_KS_DECRYPT_EN
    input  logic        decrypt_i,
`endif
    input  logic        ready_i,
    output logic [79:0] current_key_o,
    output logic [4:0]  round_o,
    output logic        valid_o,
    output logic        last_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EMIT    = 2'd1,
        ST_DONE    = 2'd2
`ifdef BORON_KS_DECRYPT_EN
        ,
        ST_PRECOMP = 2'd3
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [79:0] r_key;
    logic [79:0] w_key_nxt;
    logic [4:0]  r_round;
    logic [4:0]  w_round_nxt;
    logic [4:0]  w_round_inc;
    logic [4:0]  w_final;
    logic        w_last;

    function automatic logic [3:0] f_sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'hE;
            4'h1: y = 4'h4;
            4'h2: y = 4'hB;
            4'h3: y = 4'h1;
            4'h4: y = 4'h7;
            4'h5: y = 4'h9;
            4'h6: y = 4'hC;
            4'h7: y = 4'hA;
            4'h8: y = 4'hD;
            4'h9: y = 4'h2;
            4'hA: y = 4'h0;
            4'hB: y = 4'hF;
            4'hC: y = 4'h8;
            4'hD: y = 4'h5;
            4'hE: y = 4'h3;
            4'hF: y = 4'h6;
        endcase
        return y;
    endfunction

    // Forward step: rotate left 13, S-box low nibble, inject round index.
    function automatic logic [79:0] f_fwd(input logic [79:0] k,
                                          input logic [4:0]  i);
        logic [79:0] t;
        t        = {k[66:0], k[79:67]};
        t[3:0]   = f_sbox(t[3:0]);
        t[63:59] = t[63:59] ^ i;
        return t;
    endfunction

`ifdef BORON_KS_DECRYPT_EN
    logic r_dec;
    logic w_dec_nxt;

    function automatic logic [3:0] f_sinv(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'hA;
            4'h1: y = 4'h3;
            4'h2: y = 4'h9;
            4'h3: y = 4'hE;
            4'h4: y = 4'h1;
            4'h5: y = 4'hD;
            4'h6: y = 4'hF;
            4'h7: y = 4'h4;
            4'h8: y = 4'hC;
            4'h9: y = 4'h5;
            4'hA: y = 4'h7;
            4'hB: y = 4'h2;
            4'hC: y = 4'h6;
            4'hD: y = 4'h8;
            4'hE: y = 4'h0;
            4'hF: y = 4'hB;
        endcase
        return y;
    endfunction

    // Undo the forward step i, recovering the previous round key.
    function automatic logic [79:0] f_inv(input logic [79:0] k,
                                          input logic [4:0]  i);
        logic [79:0] t;
        t        = k;
        t[63:59] = t[63:59] ^ i;
        t[3:0]   = f_sinv(t[3:0]);
        return {t[12:0], t[79:13]};
    endfunction

    assign w_final = r_dec ? 5'd0 : 5'd25;
`else
    assign w_final = 5'd25;
`endif

    assign w_round_inc = r_round + 5'd1;
    assign w_last      = (r_round == w_final);

    assign current_key_o = r_key;
    assign round_o       = r_round;
    assign valid_o       = (r_state == ST_EMIT);
    assign last_o        = valid_o && w_last;
    assign busy_o        = (r_state != ST_IDLE);
    assign done_o        = (r_state == ST_DONE);

    // State, key and round registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_round <= '0;
`ifdef BORON_KS_DECRYPT_EN
            r_dec   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_round <= w_round_nxt;
`ifdef BORON_KS_DECRYPT_EN
            r_dec   <= w_dec_nxt;
`endif
        end
    end

    // Next state and key update for each FSM state.
    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_round_nxt = r_round;
`ifdef BORON_KS_DECRYPT_EN
        w_dec_nxt   = r_dec;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_key_nxt   = key_i;
                    w_round_nxt = 5'd0;
`ifdef BORON_KS_DECRYPT_EN
                    w_dec_nxt   = decrypt_i;
                    w_state_nxt = decrypt_i ? ST_PRECOMP : ST_EMIT;
`else
                    w_state_nxt = ST_EMIT;
`endif
                end
            end
`ifdef BORON_KS_DECRYPT_EN
            ST_PRECOMP: begin
                w_key_nxt   = f_fwd(r_key, w_round_inc);
                w_round_nxt = w_round_inc;
                if (w_round_inc == 5'd25) begin
                    w_state_nxt = ST_EMIT;
                end
            end
`endif
            ST_EMIT: begin
                if (ready_i) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
`ifdef BORON_KS_DECRYPT_EN
                    end else if (r_dec) begin
                        w_key_nxt   = f_inv(r_key, r_round);
                        w_round_nxt = r_round - 5'd1;
`endif
                    end else begin
                        w_key_nxt   = f_fwd(r_key, w_round_inc);
                        w_round_nxt = w_round_inc;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_boron_key_schedule.sv
// tb_boron_key_schedule: scoreboard bench for boron_key_schedule.
// Stimulus pushes expected keys; a negedge monitor pops on each handshake.
module tb_boron_key_schedule;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [79:0] key_i;
    logic        ready_i;
    logic [79:0] current_key_o;
    logic [4:0]  round_o;
    logic        valid_o;
    logic        last_o;
    logic        busy_o;
    logic        done_o;
`ifdef BORON_KS_DECRYPT_EN
    logic        decrypt_i;
`endif

    boron_key_schedule dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start_i),
        .key_i         (key_i),
`ifdef BORON_KS_DECRYPT_EN
        .decrypt_i     (decrypt_i),
`endif
        .ready_i       (ready_i),
        .current_key_o (current_key_o),
        .round_o       (round_o),
        .valid_o       (valid_o),
        .last_o        (last_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    typedef struct packed {
        logic [79:0] key;
        logic [4:0]  rnd;
        logic        last;
    } exp_t;

    localparam logic [63:0] SBOX = 64'h6358_F02D_AC97_1B4E;
    localparam logic [79:0] HAND_K1 = 80'h0000_0800_0000_0000_000E;
    localparam logic [79:0] HAND_K2 = 80'h0100_1000_0000_0001_C00E;

    exp_t        q[$];
    logic [79:0] ks [26];
    int          n_chk  = 0;
    int          n_fail = 0;
    bit          done_pend = 0;
    bit          stall_prev = 0;
    logic [79:0] stall_key;
    logic [4:0]  stall_rnd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [79:0] m_step(input logic [79:0] k, input int i);
        logic [79:0] r;
        logic [63:0] s;
        logic [4:0]  ii;
        s        = SBOX;
        ii       = i[4:0];
        r        = (k << 13) | (k >> 67);
        r[3:0]   = s[r[3:0]*4 +: 4];
        r[63:59] = r[63:59] ^ ii;
        return r;
    endfunction

    task automatic build(input logic [79:0] k);
        ks[0] = k;
        for (int i = 1; i < 26; i++) ks[i] = m_step(ks[i-1], i);
    endtask

    task automatic push_run(input bit dec);
        exp_t e;
        for (int j = 0; j < 26; j++) begin
            int r;
            r = dec ? 25 - j : j;
            e.key  = ks[r];
            e.rnd  = 5'(r);
            e.last = dec ? (r == 0) : (r == 25);
            q.push_back(e);
        end
    endtask

    task automatic do_start(input logic [79:0] k, input bit dec);
        int n;
        push_run(dec);
        @(posedge clk);
        #1;
        key_i   = k;
        start_i = 1'b1;
`ifdef BORON_KS_DECRYPT_EN
        decrypt_i = dec;
`endif
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        n = 1;
        while (!valid_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("first_key_latency", 80'(n), dec ? 80'd26 : 80'd1);
    endtask

    task automatic wait_done(input bit rnd);
        bit got;
        got = 0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(posedge clk);
            #1;
            if (rnd) ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done_o) got = 1;
        end
        ready_i = 1'b1;
        chk("done_seen", 80'(got), 80'd1);
        chk("queue_drained", 80'(q.size()), 80'd0);
    endtask

    task automatic wait_round(input logic [4:0] r);
        int n;
        n = 0;
        while (!(valid_o && round_o == r) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_round", 80'(round_o), 80'(r));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            done_pend  = 0;
            stall_prev = 0;
        end else begin
            if (done_o || done_pend) chk("done_pulse", 80'(done_o), 80'(done_pend));
            done_pend = 0;
            if (stall_prev) begin
                chk("stall_valid", 80'(valid_o), 80'd1);
                chk("stall_key", current_key_o, stall_key);
                chk("stall_round", 80'(round_o), 80'(stall_rnd));
            end
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    chk("unexpected_key", 80'(q.size()), 80'd1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("key", current_key_o, e.key);
                    chk("round", 80'(round_o), 80'(e.rnd));
                    chk("last", 80'(last_o), 80'(e.last));
                    if (e.last) done_pend = 1;
                end
            end
            stall_prev = valid_o && !ready_i;
            stall_key  = current_key_o;
            stall_rnd  = round_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [79:0] k;
        rst_n   = 1'b0;
        start_i = 1'b0;
        key_i   = '0;
        ready_i = 1'b0;
`ifdef BORON_KS_DECRYPT_EN
        decrypt_i = 1'b0;
`endif
        #3;
        chk("rst_key", current_key_o, 80'd0);
        chk("rst_round", 80'(round_o), 80'd0);
        chk("rst_valid", 80'(valid_o), 80'd0);
        chk("rst_last", 80'(last_o), 80'd0);
        chk("rst_busy", 80'(busy_o), 80'd0);
        chk("rst_done", 80'(done_o), 80'd0);
        #19;
        rst_n   = 1'b1;
        ready_i = 1'b1;

        build(80'd0);
        ks[0] = 80'd0;
        ks[1] = HAND_K1;
        ks[2] = HAND_K2;
        do_start(80'd0, 0);
        wait_done(0);

        k = 80'h0123_4567_89AB_CDEF_FEDC;
        build(k);
        do_start(k, 0);
        wait_round(5'd2);
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ready_i = 1'b1;
        @(negedge clk);
        chk("bp_hold_round", 80'(round_o), 80'd3);
        @(negedge clk);
        chk("bp_next_round", 80'(round_o), 80'd4);
        chk("bp_next_key", current_key_o, ks[4]);
        wait_done(0);

        for (int t = 0; t < 100; t++) begin
            k[31:0]  = $urandom();
            k[63:32] = $urandom();
            k[79:64] = 16'($urandom());
            build(k);
            do_start(k, 0);
            wait_done(1);
        end

        k = 80'hA5A5_0F0F_1234_5678_9ABC;
        build(k);
        do_start(k, 0);
        repeat (5) @(posedge clk);
        #1;
        key_i   = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("midstart_busy", 80'(busy_o), 80'd1);
        wait_done(0);
        repeat (2) @(negedge clk);
        chk("midstart_idle", 80'(busy_o), 80'd0);

        k = 80'h1357_9BDF_2468_ACE0_1122;
        build(k);
        do_start(k, 0);
        wait_round(5'd10);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mrst_key", current_key_o, 80'd0);
        chk("mrst_round", 80'(round_o), 80'd0);
        chk("mrst_valid", 80'(valid_o), 80'd0);
        chk("mrst_last", 80'(last_o), 80'd0);
        chk("mrst_busy", 80'(busy_o), 80'd0);
        chk("mrst_done", 80'(done_o), 80'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("mrst_hold_valid", 80'(valid_o), 80'd0);
        rst_n = 1'b1;
        k = 80'hDEAD_BEEF_CAFE_F00D_0042;
        build(k);
        do_start(k, 0);
        wait_done(0);

`ifdef BORON_KS_DECRYPT_EN
        build(80'd0);
        do_start(80'd0, 1);
        wait_done(0);
        k = 80'h0F1E_2D3C_4B5A_6978_8796;
        build(k);
        do_start(k, 1);
        wait_done(1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
